// File: rtl/pong_tick_gen.sv
// Multi-channel clock-enable generator: one-cycle tick strobes every d cycles per
// channel, with glitch-free divisor updates, phase resync and a registered square wave.
module pong_tick_gen #(
  parameter int                        NUM_CH   = 3,
  parameter int                        CNT_W    = 24,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {24'd50000, 24'd833333, 24'd2},
  parameter int                        CTRL_CH  = 1
) (
  input  logic              clk_50Mhz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [3:0]        div_sel,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic              clk_ctrl
);

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  act     [NUM_CH];
  logic [CNT_W-1:0]  pend    [NUM_CH];
  logic [CNT_W-1:0]  nxt_div [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] term;

  // A same-cycle write bypasses pend so it is never lost when act reloads on that edge.
  // Divisors 0 and 1 both collapse to a terminal count of zero.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]  = div_wr && (div_sel == 4'(i));
      nxt_div[i] = wr_hit[i] ? div_val : pend[i];
      term[i]    = (act[i] <= CNT_W'(1)) ? (cnt[i] == '0)
                                         : (cnt[i] == act[i] - CNT_W'(1));
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      // NOTE: these per-channel arrays are plain flops (not RAM) and must restart from
      // DIV_INIT, so resetting them in a loop is intentional.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        act[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
        pend[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
      tick     <= '0;
      clk_ctrl <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) pend[i] <= div_val;
      end

      if (sync) begin
        for (int i = 0; i < NUM_CH; i++) begin
          cnt[i] <= '0;
          act[i] <= nxt_div[i];
        end
        tick     <= '0;
        clk_ctrl <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (!ch_en[i]) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b0;
            act[i]  <= nxt_div[i];
          end else if (term[i]) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
            act[i]  <= nxt_div[i];
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end
        if (ch_en[CTRL_CH] && term[CTRL_CH]) clk_ctrl <= ~clk_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pong_tick_gen.sv
// Directed bench for pong_tick_gen with DIV_INIT = {5, 3, 2} and CTRL_CH = 1.
// Edge numbers count posedges after reset release; outputs are sampled 1 ns after each edge.
module tb_pong_tick_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;

  logic              clk_50Mhz = 1'b0;
  logic              rst       = 1'b1;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic              div_wr    = 1'b0;
  logic [3:0]        div_sel   = '0;
  logic [CNT_W-1:0]  div_val   = '0;
  logic              sync      = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic              clk_ctrl;

  int checks = 0;
  int errors = 0;

  pong_tick_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_INIT({24'd5, 24'd3, 24'd2}),
    .CTRL_CH (1)
  ) dut (
    .clk_50Mhz(clk_50Mhz),
    .rst      (rst),
    .ch_en    (ch_en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .sync     (sync),
    .tick     (tick),
    .clk_ctrl (clk_ctrl)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_50Mhz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_en = '0; div_wr = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '1; div_wr = 1'b0; sync = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (tick !== 3'b000) begin
        errors++;
        $display("FAIL reset_tick cycle %0d: got %b expected 000", c, tick);
      end
      checks++;
      if (clk_ctrl !== 1'b0) begin
        errors++;
        $display("FAIL reset_clk_ctrl cycle %0d: got %b expected 0", c, clk_ctrl);
      end
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_t;
    logic       exp_c;
    do_reset();
    ch_en = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      step();
      exp_t = {(e % 5 == 0), (e % 3 == 0), (e % 2 == 0)};
      exp_c = ((e / 3) % 2) == 1;
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL basic_tick edge %0d: got %b expected %b", e, tick, exp_t);
      end
      checks++;
      if (clk_ctrl !== exp_c) begin
        errors++;
        $display("FAIL basic_clk_ctrl edge %0d: got %b expected %b", e, clk_ctrl, exp_c);
      end
    end
  endtask

  // ch1 rewritten to 6 at wr_edge; the period in flight keeps d=3.
  task automatic test_div_change(input int wr_edge);
    logic exp_t1;
    logic exp_c;
    do_reset();
    ch_en = 3'b111;
    for (int e = 1; e <= 16; e++) begin
      div_wr  = (e == wr_edge);
      div_sel = 4'd1;
      div_val = 24'd6;
      step();
      exp_t1 = (e == 3) || (e == 9) || (e == 15);
      exp_c  = (e >= 3 && e < 9) || (e >= 15);
      checks++;
      if (tick[1] !== exp_t1) begin
        errors++;
        $display("FAIL div_change_w%0d_tick1 edge %0d: got %b expected %b", wr_edge, e, tick[1], exp_t1);
      end
      checks++;
      if (clk_ctrl !== exp_c) begin
        errors++;
        $display("FAIL div_change_w%0d_clk_ctrl edge %0d: got %b expected %b", wr_edge, e, clk_ctrl, exp_c);
      end
    end
    div_wr = 1'b0;
  endtask

  // ch0 = 0 at edge 1, ch0 = 1 at edge 9, then out-of-range writes to sel 7 and 3.
  task automatic test_div_zero_one();
    logic [2:0] exp_t;
    do_reset();
    ch_en = 3'b111;
    for (int e = 1; e <= 30; e++) begin
      div_wr = 1'b0;
      if (e == 1)  begin div_wr = 1'b1; div_sel = 4'd0; div_val = 24'd0; end
      if (e == 9)  begin div_wr = 1'b1; div_sel = 4'd0; div_val = 24'd1; end
      if (e == 15) begin div_wr = 1'b1; div_sel = 4'd7; div_val = 24'd4; end
      if (e == 16) begin div_wr = 1'b1; div_sel = 4'd3; div_val = 24'd4; end
      step();
      exp_t = {(e % 5 == 0), (e % 3 == 0), (e >= 2)};
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL div_zero_one_tick edge %0d: got %b expected %b", e, tick, exp_t);
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_disable();
    logic [2:0] exp_t;
    do_reset();
    ch_en = 3'b111;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3)  ch_en[2] = 1'b0;
      if (e == 10) ch_en[2] = 1'b1;
      step();
      exp_t = {(e == 14 || e == 19), (e % 3 == 0), (e % 2 == 0)};
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL disable_tick edge %0d: got %b expected %b", e, tick, exp_t);
      end
    end
  endtask

  // Skewed enables: ch0 from edge 1, ch2 from edge 2, ch1 from edge 4; sync at edge 20.
  task automatic test_sync();
    logic [2:0] exp_t;
    logic       exp_c;
    int         k;
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      if (e == 1) ch_en = 3'b001;
      if (e == 2) ch_en = 3'b101;
      if (e == 4) ch_en = 3'b111;
      sync = (e == 20);
      step();
      if (e < 20) begin
        exp_t = {(e >= 6 && (e - 1) % 5 == 0), (e >= 6 && e % 3 == 0), (e % 2 == 0)};
        exp_c = (e >= 6) && (((e - 6) / 3) % 2 == 0);
      end else begin
        k = e - 20;
        exp_t = {(k > 0 && k % 5 == 0), (k > 0 && k % 3 == 0), (k > 0 && k % 2 == 0)};
        exp_c = (k >= 3 && k < 6);
      end
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL sync_tick edge %0d: got %b expected %b", e, tick, exp_t);
      end
      checks++;
      if (clk_ctrl !== exp_c) begin
        errors++;
        $display("FAIL sync_clk_ctrl edge %0d: got %b expected %b", e, clk_ctrl, exp_c);
      end
    end
    sync = 1'b0;
  endtask

  // ch0 rewritten to 4 before a mid-run reset at edges 7-8; afterwards d must be back to 2.
  task automatic test_rst_mid();
    logic [2:0] exp_t;
    logic       exp_c;
    int         k;
    do_reset();
    ch_en = 3'b111;
    for (int e = 1; e <= 18; e++) begin
      div_wr  = (e == 1);
      div_sel = 4'd0;
      div_val = 24'd4;
      rst     = (e == 7 || e == 8);
      step();
      if (e <= 6) begin
        exp_t = {(e == 5), (e == 3 || e == 6), (e == 2 || e == 6)};
        exp_c = (e >= 3 && e < 6);
      end else if (e <= 8) begin
        exp_t = 3'b000;
        exp_c = 1'b0;
      end else begin
        k = e - 8;
        exp_t = {(k % 5 == 0), (k % 3 == 0), (k % 2 == 0)};
        exp_c = ((k / 3) % 2) == 1;
      end
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL rst_mid_tick edge %0d: got %b expected %b", e, tick, exp_t);
      end
      checks++;
      if (clk_ctrl !== exp_c) begin
        errors++;
        $display("FAIL rst_mid_clk_ctrl edge %0d: got %b expected %b", e, clk_ctrl, exp_c);
      end
    end
    rst    = 1'b0;
    div_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change(1);
    test_div_change(3);
    test_div_zero_one();
    test_disable();
    test_sync();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
